// File: rtl/mod_mul_arbiter.sv
// mod_mul_arbiter
//
// Shares one modular multiplier (q = 3329, 12-bit operands) among NUM_REQ
// requesters. Requesters are granted round-robin. Each granted operation is
// issued to the multiplier, its done pulse is awaited, and the result is
// returned tagged with the requester id. A watchdog aborts a transaction if
// the multiplier never answers, so requesters cannot be stuck forever.
//
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   req_valid          per-requester request valid (held until accepted)
//   req_a, req_b       packed 12-bit operands, slice i belongs to requester i
//   req_ready          one-hot accept, combinational in IDLE
//   resp_valid         one-cycle response pulse
//   resp_id            requester id of the response
//   resp_r             product mod 3329, 0 on timeout
//   resp_err           1 = watchdog timeout
//   arb_busy           high whenever the FSM is not IDLE
//   mul_en             one-cycle start pulse to the multiplier
//   mul_a, mul_b       operands held stable towards the multiplier
//   mul_busy           multiplier busy, blocks new grants
//   mul_done, mul_r    multiplier completion pulse and result

module mod_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [12*NUM_REQ-1:0] req_a,
  input  logic [12*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [11:0]           resp_r,
  output logic                  resp_err,
  output logic                  arb_busy,
  output logic                  mul_en,
  output logic [11:0]           mul_a,
  output logic [11:0]           mul_b,
  input  logic                  mul_busy,
  input  logic                  mul_done,
  input  logic [11:0]           mul_r
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  state_t          state_next;
  logic [ID_W-1:0] last_gnt;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic            grant;
  logic            timeout;
  logic [WD_W-1:0] wd_cnt;
  logic [11:0]     sel_a;
  logic [11:0]     sel_b;

  // Round-robin search starting just after the last winner, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = ID_W'((int'(last_gnt) + off) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Operand slice of the candidate winner.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[i*12 +: 12];
        sel_b = req_b[i*12 +: 12];
      end
    end
  end

  // rst gates req_ready so no accept is advertised while held in reset.
  assign grant     = (state == IDLE) && !rst && !mul_busy && grant_found;
  assign req_ready = grant ? (NUM_REQ'(1) << grant_idx) : '0;
  assign timeout   = (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mul_en     = 1'b0;
    resp_valid = 1'b0;
    arb_busy   = 1'b1;
    case (state)
      IDLE: begin
        arb_busy = 1'b0;
        if (grant) state_next = ISSUE;
      end
      ISSUE: begin
        mul_en     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (mul_done || timeout) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // mul_done has priority over the watchdog when both land in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a    <= '0;
      mul_b    <= '0;
      cur_id   <= '0;
      last_gnt <= ID_W'(NUM_REQ - 1);
      wd_cnt   <= '0;
      resp_id  <= '0;
      resp_r   <= '0;
      resp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            mul_a    <= sel_a;
            mul_b    <= sel_b;
            cur_id   <= grant_idx;
            last_gnt <= grant_idx;
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
        end
        WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (mul_done) begin
            resp_r   <= mul_r;
            resp_err <= 1'b0;
            resp_id  <= cur_id;
          end else if (timeout) begin
            resp_r   <= '0;
            resp_err <= 1'b1;
            resp_id  <= cur_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mul_arbiter.sv
// Testbench for mod_mul_arbiter: directed scenarios with a behavioural
// multiplier (fixed latency, optional hang) and per-requester drivers that
// hold req_valid until accepted.

module tb_mod_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 64;
  localparam int LAT     = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [12*NUM_REQ-1:0] req_a;
  logic [12*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  resp_valid;
  logic [ID_W-1:0]       resp_id;
  logic [11:0]           resp_r;
  logic                  resp_err;
  logic                  arb_busy;
  logic                  mul_en;
  logic [11:0]           mul_a;
  logic [11:0]           mul_b;
  logic                  mul_busy;
  logic                  mul_done = 1'b0;
  logic [11:0]           mul_r = '0;

  int checks   = 0;
  int failures = 0;

  int          want [NUM_REQ];
  logic [11:0] op_a [NUM_REQ];
  logic [11:0] op_b [NUM_REQ];

  logic force_busy = 1'b0;
  logic hang       = 1'b0;
  logic model_pend = 1'b0;
  int   model_cnt  = 0;
  logic [11:0] model_r = '0;

  int cyc = 0;
  logic [NUM_REQ-1:0] acc_mask = '0;
  int grant_q[$];
  int rid_q[$];
  int rr_q[$];
  int re_q[$];
  int rcyc_q[$];
  int ecyc_q[$];

  mod_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_r(resp_r), .resp_err(resp_err),
    .arb_busy(arb_busy), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_busy(mul_busy), .mul_done(mul_done), .mul_r(mul_r)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign req_a[g*12 +: 12] = op_a[g];
    assign req_b[g*12 +: 12] = op_b[g];
  end

  assign mul_busy = force_busy | model_pend;

  // Behavioural multiplier: done LAT cycles after mul_en; not reset by rst so
  // an aborted operation can still complete while the arbiter is idle.
  always @(posedge clk) begin
    mul_done <= 1'b0;
    mul_r    <= 12'hEEE;
    if (mul_en && !hang) begin
      model_pend <= 1'b1;
      model_cnt  <= LAT - 1;
      model_r    <= 12'((int'(mul_a) * int'(mul_b)) % 3329);
    end else if (model_pend) begin
      if (model_cnt == 1) begin
        mul_done   <= 1'b1;
        mul_r      <= model_r;
        model_pend <= 1'b0;
      end else begin
        model_cnt <= model_cnt - 1;
      end
    end
  end

  // Requesters: keep valid while transactions remain, count down on accept.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_mask[i] && want[i] > 0) want[i]--;
      req_valid[i] = (want[i] > 0);
    end
  end

  // Monitor sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    acc_mask = req_valid & req_ready;
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) if (acc_mask[i]) grant_q.push_back(i);
      if (mul_en) ecyc_q.push_back(cyc);
      if (resp_valid) begin
        rid_q.push_back(int'(resp_id));
        rr_q.push_back(int'(resp_r));
        re_q.push_back(int'(resp_err));
        rcyc_q.push_back(cyc);
      end
    end
  end

  task automatic clear_queues();
    grant_q.delete(); rid_q.delete(); rr_q.delete();
    re_q.delete(); rcyc_q.delete(); ecyc_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if ({resp_valid, resp_err, mul_en, arb_busy} !== 4'b0000) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=0000", {resp_valid, resp_err, mul_en, arb_busy}); end
    checks++; if (resp_id !== 2'd0) begin failures++; $display("[TB] FAIL reset_id got=%0d exp=0", resp_id); end
    checks++; if (resp_r !== 12'd0) begin failures++; $display("[TB] FAIL reset_r got=%0d exp=0", resp_r); end
    checks++; if ({mul_a, mul_b} !== 24'd0) begin failures++; $display("[TB] FAIL reset_ops got=%h exp=0", {mul_a, mul_b}); end
    @(posedge clk); #2; rst = 1'b0;
  endtask

  task automatic test_single();
    int n;
    op_a[0] = 12'd3328; op_b[0] = 12'd3328;
    @(negedge clk); clear_queues(); want[0] = 1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL single_ready got=%b exp=0001", req_ready); end
    @(negedge clk);
    checks++; if (mul_en !== 1'b1) begin failures++; $display("[TB] FAIL single_en got=%b exp=1", mul_en); end
    checks++; if ({mul_a, mul_b} !== {12'd3328, 12'd3328}) begin failures++; $display("[TB] FAIL single_ops got=%0d,%0d exp=3328,3328", mul_a, mul_b); end
    checks++; if ({req_ready, arb_busy} !== 5'b00001) begin failures++; $display("[TB] FAIL single_issue_state got=%b exp=00001", {req_ready, arb_busy}); end
    @(negedge clk);
    checks++; if (mul_en !== 1'b0) begin failures++; $display("[TB] FAIL single_en_pulse got=%b exp=0", mul_en); end
    n = 0;
    while (rid_q.size() < 1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (rid_q.size() != 1) begin failures++; $display("[TB] FAIL single_resp_count got=%0d exp=1", rid_q.size()); end
    checks++; if ({rid_q[0], rr_q[0], re_q[0]} != {32'd0, 32'd1, 32'd0}) begin failures++; $display("[TB] FAIL single_resp got=id%0d r%0d err%0d exp=id0 r1 err0", rid_q[0], rr_q[0], re_q[0]); end
    checks++; if (rcyc_q[0] - ecyc_q[0] != LAT + 1) begin failures++; $display("[TB] FAIL single_latency got=%0d exp=%0d", rcyc_q[0] - ecyc_q[0], LAT + 1); end
  endtask

  task automatic test_contention();
    int n;
    int exp_r[4] = '{0, 1, 1713, 852};
    @(negedge clk); rst = 1'b1;
    op_a[0] = 12'd0;    op_b[0] = 12'd0;
    op_a[1] = 12'd1;    op_b[1] = 12'd1;
    op_a[2] = 12'd3000; op_b[2] = 12'd3000;
    op_a[3] = 12'd4095; op_b[3] = 12'd4095;
    for (int i = 0; i < NUM_REQ; i++) want[i] = 1;
    repeat (2) @(negedge clk);
    clear_queues();
    @(posedge clk); #2; rst = 1'b0;
    n = 0;
    while (rid_q.size() < 4 && n < 80) begin @(negedge clk); n++; end
    checks++; if (rid_q.size() != 4) begin failures++; $display("[TB] FAIL cont_resp_count got=%0d exp=4", rid_q.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (grant_q[k] != k) begin failures++; $display("[TB] FAIL cont_grant[%0d] got=%0d exp=%0d", k, grant_q[k], k); end
      checks++; if (rid_q[k] != k) begin failures++; $display("[TB] FAIL cont_id[%0d] got=%0d exp=%0d", k, rid_q[k], k); end
      checks++; if (rr_q[k] != exp_r[k] || re_q[k] != 0) begin failures++; $display("[TB] FAIL cont_r[%0d] got=%0d err%0d exp=%0d err0", k, rr_q[k], re_q[k], exp_r[k]); end
    end
    checks++; if (ecyc_q.size() != 4) begin failures++; $display("[TB] FAIL cont_en_count got=%0d exp=4", ecyc_q.size()); end
  endtask

  task automatic test_rotation();
    int n;
    op_a[1] = 12'd5;   op_b[1] = 12'd7;
    op_a[3] = 12'd100; op_b[3] = 12'd200;
    @(negedge clk); clear_queues(); want[1] = 3; want[3] = 3;
    n = 0;
    while (rid_q.size() < 6 && n < 100) begin @(negedge clk); n++; end
    checks++; if (rid_q.size() != 6) begin failures++; $display("[TB] FAIL rot_resp_count got=%0d exp=6", rid_q.size()); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (grant_q[k] != ((k % 2) ? 3 : 1)) begin failures++; $display("[TB] FAIL rot_grant[%0d] got=%0d exp=%0d", k, grant_q[k], (k % 2) ? 3 : 1); end
      checks++; if (rid_q[k] != ((k % 2) ? 3 : 1) || rr_q[k] != ((k % 2) ? 26 : 35)) begin failures++; $display("[TB] FAIL rot_resp[%0d] got=id%0d r%0d exp=id%0d r%0d", k, rid_q[k], rr_q[k], (k % 2) ? 3 : 1, (k % 2) ? 26 : 35); end
    end
  endtask

  task automatic test_busy_gate();
    int n;
    op_a[1] = 12'd10; op_b[1] = 12'd20;
    @(negedge clk); clear_queues(); force_busy = 1'b1; want[1] = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL busy_ready[%0d] got=%b exp=0000", k, req_ready); end
    end
    @(posedge clk); #2; force_busy = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("[TB] FAIL busy_release_ready got=%b exp=0010", req_ready); end
    n = 0;
    while (rid_q.size() < 1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (rid_q[0] != 1 || rr_q[0] != 200 || grant_q.size() != 1) begin failures++; $display("[TB] FAIL busy_resp got=id%0d r%0d grants%0d exp=id1 r200 grants1", rid_q[0], rr_q[0], grant_q.size()); end
  endtask

  task automatic test_watchdog();
    int n;
    op_a[2] = 12'd7;    op_b[2] = 12'd8;
    op_a[0] = 12'd3328; op_b[0] = 12'd3328;
    @(negedge clk); clear_queues(); hang = 1'b1; want[2] = 1; want[0] = 1;
    n = 0;
    while (ecyc_q.size() < 1 && n < 10) begin @(negedge clk); n++; end
    @(negedge clk); hang = 1'b0;
    n = 0;
    while (rid_q.size() < 2 && n < 200) begin @(negedge clk); n++; end
    checks++; if (rid_q.size() != 2) begin failures++; $display("[TB] FAIL wd_resp_count got=%0d exp=2", rid_q.size()); end
    checks++; if ({rid_q[0], rr_q[0], re_q[0]} != {32'd2, 32'd0, 32'd1}) begin failures++; $display("[TB] FAIL wd_timeout_resp got=id%0d r%0d err%0d exp=id2 r0 err1", rid_q[0], rr_q[0], re_q[0]); end
    checks++; if (rcyc_q[0] - ecyc_q[0] != TIMEOUT + 1) begin failures++; $display("[TB] FAIL wd_latency got=%0d exp=%0d", rcyc_q[0] - ecyc_q[0], TIMEOUT + 1); end
    checks++; if ({rid_q[1], rr_q[1], re_q[1]} != {32'd0, 32'd1, 32'd0}) begin failures++; $display("[TB] FAIL wd_next_resp got=id%0d r%0d err%0d exp=id0 r1 err0", rid_q[1], rr_q[1], re_q[1]); end
    checks++; if (rcyc_q[1] - ecyc_q[1] != LAT + 1) begin failures++; $display("[TB] FAIL wd_next_latency got=%0d exp=%0d", rcyc_q[1] - ecyc_q[1], LAT + 1); end
  endtask

  task automatic test_reset_in_wait();
    int n;
    op_a[3] = 12'd100; op_b[3] = 12'd100;
    @(negedge clk); want[3] = 1;
    n = 0;
    while (mul_en !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (mul_en !== 1'b1) begin failures++; $display("[TB] FAIL rstw_issue got=%b exp=1", mul_en); end
    @(posedge clk); #2;
    @(posedge clk); #2; rst = 1'b1;
    #1;
    checks++; if ({req_ready, resp_valid, resp_err, mul_en, arb_busy} !== 8'd0) begin failures++; $display("[TB] FAIL rstw_flags got=%b exp=0", {req_ready, resp_valid, resp_err, mul_en, arb_busy}); end
    checks++; if ({resp_id, resp_r} !== 14'd0) begin failures++; $display("[TB] FAIL rstw_resp got=%h exp=0", {resp_id, resp_r}); end
    checks++; if ({mul_a, mul_b} !== 24'd0) begin failures++; $display("[TB] FAIL rstw_ops got=%h exp=0", {mul_a, mul_b}); end
    clear_queues();
    @(posedge clk); #2; rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (rid_q.size() != 0 || arb_busy !== 1'b0) begin failures++; $display("[TB] FAIL rstw_no_resp got=%0d busy%b exp=0 busy0", rid_q.size(), arb_busy); end
    op_a[0] = 12'd2; op_b[0] = 12'd1665;
    want[0] = 1;
    n = 0;
    while (rid_q.size() < 1 && n < 20) begin @(negedge clk); n++; end
    checks++; if ({rid_q[0], rr_q[0], re_q[0]} != {32'd0, 32'd1, 32'd0}) begin failures++; $display("[TB] FAIL rstw_after got=id%0d r%0d err%0d exp=id0 r1 err0", rid_q[0], rr_q[0], re_q[0]); end
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      want[i] = 0; op_a[i] = '0; op_b[i] = '0;
    end
    test_reset();
    test_single();
    test_contention();
    test_rotation();
    test_busy_gate();
    test_watchdog();
    test_reset_in_wait();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
